// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST engine: FSM state encoding and
// common two-input truth tables.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/gate_bist_if.sv
// Stimulus/result bundle between the BIST engine (slave) and its user,
// which also owns the gate under test (master).
interface gate_bist_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            dut_out;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN-1:0] fail_vec;
    logic [N_IN:0]   err_count;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, fail_vec, err_count
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, fail_vec, err_count
    );
endinterface

// File: rtl/gate_bist_settle_timer.sv
// Settle timer: counts cycles since clear and pulses expire for one cycle
// when the count reaches SETTLE, then wraps to zero for the next vector.
module bist_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);
    localparam int            W     = $clog2(SETTLE + 1);
    localparam logic [W-1:0]  LIMIT = W'(SETTLE);

    logic [W-1:0] r_count;

    assign expire = (r_count == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/gate_bist.sv
// Exhaustive BIST for an N_IN-input combinational gate: steps every input
// vector, samples the gate after a settle time and records mismatches.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 2,
    parameter logic [2**N_IN-1:0]    EXPECT = TT_AND2
) (
    input logic        clk,
    input logic        rst_n,
    gate_bist_if.slave bus
);
    // Counter is one bit wider than the vector so the terminal value never wraps.
    localparam logic [N_IN:0] LAST_VEC = (N_IN + 1)'(2**N_IN - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [N_IN:0]   r_vec;
    logic [N_IN-1:0] r_fail_vec;
    logic [N_IN:0]   r_err_count;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_first_seen;

    logic w_start_acc;
    logic w_expire;
    logic w_mismatch;
    logic w_last;

    assign w_start_acc = (r_state != RUN) && bus.start;
    assign w_mismatch  = (bus.dut_out != EXPECT[r_vec[N_IN-1:0]]);
    assign w_last      = (r_vec == LAST_VEC);

    bist_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (r_state != RUN),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (bus.start) w_state_next = RUN;
            RUN:        if (w_expire && w_last) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= '0;
            r_fail_vec   <= '0;
            r_err_count  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_first_seen <= 1'b0;
        end else if (w_start_acc) begin
            r_vec        <= '0;
            r_fail_vec   <= '0;
            r_err_count  <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_first_seen <= 1'b0;
        end else if (r_state == RUN && w_expire) begin
            if (w_mismatch) begin
                r_err_count <= r_err_count + 1'b1;
                if (!r_first_seen) begin
                    r_fail_vec   <= r_vec[N_IN-1:0];
                    r_first_seen <= 1'b1;
                end
            end
            if (!w_last) begin
                r_vec <= r_vec + 1'b1;
            end else begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                // Pass must include the verdict of this final compare.
                r_pass <= (r_err_count == '0) && !w_mismatch;
            end
        end
    end

    assign bus.dut_in    = r_vec[N_IN-1:0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_vec  = r_fail_vec;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: table of runs on the default 2-input
// engine with a scoreboard queue, plus reset, held-start and N_IN=3 sequences.
module tb_gate_bist;
    import gate_bist_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   gate_mode = 0;  // 0 = AND, 1 = OR, 2 = stuck at 0
    int   n_tests   = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    gate_bist_if #(.N_IN(2)) bus2 ();
    gate_bist_if #(.N_IN(3)) bus3 ();

    assign bus2.dut_out = (gate_mode == 0) ? (&bus2.dut_in) :
                          (gate_mode == 1) ? (|bus2.dut_in) : 1'b0;
    assign bus3.dut_out = &bus3.dut_in;

    gate_bist #(
        .N_IN   (2),
        .SETTLE (2),
        .EXPECT (TT_AND2)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    gate_bist #(
        .N_IN   (3),
        .SETTLE (1),
        .EXPECT (8'b1000_0000)
    ) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    typedef struct {
        int mode;
        bit hold;
        bit pass;
        int err;
        int fv;
        int lat;
    } vec_t;

    vec_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run2(input vec_t v);
        int   k;
        vec_t got;
        sb_q.push_back(v);
        gate_mode = v.mode;
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);  // E0
        k = 0;
        @(negedge clk);
        if (!v.hold) bus2.start = 1'b0;
        chk("clr_done", bus2.done, 0);
        chk("clr_pass", bus2.pass, 0);
        chk("clr_err", bus2.err_count, 0);
        chk("clr_fv", bus2.fail_vec, 0);
        while (!bus2.done && k < 200) begin
            chk("dut_in_step", bus2.dut_in, k / 3);
            chk("busy_run", bus2.busy, 1);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        bus2.start = 1'b0;
        got = sb_q.pop_front();
        chk("done_latency", k, got.lat);
        chk("pass", bus2.pass, got.pass);
        chk("err_count", bus2.err_count, got.err);
        chk("fail_vec", bus2.fail_vec, got.fv);
        chk("busy_done", bus2.busy, 0);
        $display("[TB] run mode=%0d hold=%0b done after %0d cycles pass=%0b err=%0d fail_vec=%0d",
                 v.mode, v.hold, k, bus2.pass, bus2.err_count, bus2.fail_vec);
        repeat (3) @(negedge clk);
        chk("hold_done", bus2.done, 1);
        chk("hold_err", bus2.err_count, got.err);
        chk("hold_dut_in", bus2.dut_in, 3);
    endtask

    vec_t tbl[5];

    initial begin
        int k;
        tbl[0] = '{mode: 0, hold: 1'b0, pass: 1'b1, err: 0, fv: 0, lat: 12};
        tbl[1] = '{mode: 1, hold: 1'b0, pass: 1'b0, err: 2, fv: 1, lat: 12};
        tbl[2] = '{mode: 2, hold: 1'b0, pass: 1'b0, err: 1, fv: 3, lat: 12};
        tbl[3] = '{mode: 0, hold: 1'b0, pass: 1'b1, err: 0, fv: 0, lat: 12};
        tbl[4] = '{mode: 0, hold: 1'b1, pass: 1'b1, err: 0, fv: 0, lat: 12};

        bus2.start = 1'b0;
        bus3.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dut_in", bus2.dut_in, 0);
        chk("rst_busy", bus2.busy, 0);
        chk("rst_done", bus2.done, 0);
        chk("rst_pass", bus2.pass, 0);
        chk("rst_fv", bus2.fail_vec, 0);
        chk("rst_err", bus2.err_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus2.busy, 0);

        for (int i = 0; i < 5; i++) begin
            run2(tbl[i]);
        end

        // Asynchronous reset in the middle of a run.
        gate_mode = 0;
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_busy", bus2.busy, 1);
        chk("mid_dut_in", bus2.dut_in, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_dut_in", bus2.dut_in, 0);
        chk("arst_busy", bus2.busy, 0);
        chk("arst_done", bus2.done, 0);
        chk("arst_pass", bus2.pass, 0);
        chk("arst_fv", bus2.fail_vec, 0);
        chk("arst_err", bus2.err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", bus2.busy, 0);
        chk("post_rst_dut_in", bus2.dut_in, 0);
        run2(tbl[0]);

        // Three-input AND with a single settle cycle.
        @(negedge clk);
        bus3.start = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        bus3.start = 1'b0;
        while (!bus3.done && k < 200) begin
            chk("n3_dut_in_step", bus3.dut_in, k / 2);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("n3_latency", k, 16);
        chk("n3_pass", bus3.pass, 1);
        chk("n3_err", bus3.err_count, 0);
        chk("n3_fv", bus3.fail_vec, 0);
        chk("n3_dut_in_last", bus3.dut_in, 7);
        $display("[TB] run n_in=3 done after %0d cycles pass=%0b err=%0d", k, bus3.pass, bus3.err_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
